// File: rtl/trans_protocol_rx.sv
// trans_protocol_rx: serial receive stage; recovers DATA_W-bit packet words from a one-bit-per-clock stream
// Ports:
//   clk, rst_n (async, active-low)   S_Data: serial line, idles low   rx_ack: core consumed RX_Data
//   RX_Data: recovered word, first bit in MSB   pkt_type: RX_Data top 3 bits
//   rx_valid: word held until rx_ack   busy: frame shifting in   overrun: 1-cycle pulse, word lost
// Optional macro RX_SYNC_EN: 2-flop synchronizer on S_Data (all latencies +2 cycles).
module trans_protocol_rx #(
  parameter int DATA_W = 55,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              S_Data,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] RX_Data,
  output logic [2:0]        pkt_type,
  output logic              rx_valid,
  output logic              busy,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shadow;
  logic              w_sd;
  logic              w_last;
`ifdef RX_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= {r_sync[0], S_Data};
  assign w_sd = r_sync[1];
`else
  assign w_sd = S_Data;
`endif
  assign pkt_type = RX_Data[DATA_W-1 -: 3];
  assign w_last   = r_cnt == CNT_W'(DATA_W-1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      RX_Data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_ack) rx_valid <= 1'b0;
      case (r_state)
        IDLE: r_state <= w_sd ? IDLE : ARMED;
        ARMED: if (w_sd) begin
          r_state <= SHIFT;
          r_cnt   <= '0;
          busy    <= 1'b1;
        end
        SHIFT: begin
          r_shadow <= {r_shadow[DATA_W-2:0], w_sd};
          r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
          if (w_last) r_state <= DONE;
        end
        DONE: begin
          // load beats a coincident rx_ack; only an unacknowledged held word is an overrun
          RX_Data  <= r_shadow;
          rx_valid <= 1'b1;
          busy     <= 1'b0;
          overrun  <= rx_valid && !rx_ack;
          // the line is evaluated as in IDLE so a back-to-back sync "0" is not lost
          r_state  <= w_sd ? IDLE : ARMED;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trans_protocol_rx.sv
// tb_trans_protocol_rx: randomized frame stream checked against a frame-schedule model
module tb_trans_protocol_rx;
`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, S_Data = 1'b0, rx_ack = 1'b0;
  logic [54:0] RX_Data;
  logic [2:0]  pkt_type;
  logic        rx_valid, busy, overrun;
  trans_protocol_rx dut (
    .clk(clk), .rst_n(rst_n), .S_Data(S_Data), .rx_ack(rx_ack),
    .RX_Data(RX_Data), .pkt_type(pkt_type), .rx_valid(rx_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int          n_cmp = 0, n_bad = 0, edge_n = 0, ovr_cnt = 0;
  bit          ack_rand = 1'b0, ack_man = 1'b0;
  logic [54:0] load_at[int];
  bit          rise_at[int];
  logic        m_valid = 1'b0, m_busy = 1'b0, m_ovr = 1'b0;
  logic [54:0] m_data = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // frame schedule model: each frame's busy-rise and word-load edges are known when it is sent
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_ovr   <= 1'b0;
      m_data  <= '0;
      load_at.delete();
      rise_at.delete();
    end else begin
      if (rise_at.exists(edge_n)) m_busy <= 1'b1;
      if (load_at.exists(edge_n)) begin
        m_ovr   <= m_valid && !rx_ack;
        m_valid <= 1'b1;
        m_data  <= load_at[edge_n];
        m_busy  <= 1'b0;
      end else begin
        m_ovr <= 1'b0;
        if (rx_ack) m_valid <= 1'b0;
      end
      edge_n <= edge_n + 1;
    end
  end
  always @(negedge clk) begin
    chk("rx_valid", 64'(rx_valid), 64'(m_valid));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("RX_Data", 64'(RX_Data), 64'(m_data));
    chk("pkt_type", 64'(pkt_type), 64'(m_data[54:52]));
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end
  task automatic drive_bit(input logic b);
    @(negedge clk);
    S_Data = b;
    rx_ack = ack_rand ? ($urandom_range(0, 3) == 0) : ack_man;
  endtask
  task automatic start_frame(input logic [54:0] w);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rise_at[edge_n + LAT] = 1'b1;
    load_at[edge_n + 56 + LAT] = w;
  endtask
  task automatic send_frame(input logic [54:0] w);
    start_frame(w);
    for (int i = 54; i >= 0; i--) drive_bit(w[i]);
  endtask
  task automatic ack_pulse();
    ack_man = 1'b1;
    drive_bit(1'b0);
    ack_man = 1'b0;
    drive_bit(1'b0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    S_Data = 1'b0;
    rx_ack = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(rx_valid), 64'(0));
    chk("rst_data", 64'(RX_Data), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask
  task automatic token_check(input string tag);
    repeat (LAT + 1) drive_bit(1'b0);
    chk({tag, "_pre_valid"}, 64'(rx_valid), 64'(0));
    chk({tag, "_pre_busy"}, 64'(busy), 64'(1));
    drive_bit(1'b0);
    chk({tag, "_valid"}, 64'(rx_valid), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_data"}, 64'(RX_Data), 64'(55'h70_0000_0000_0000));
    chk({tag, "_type"}, 64'(pkt_type), 64'(3'b111));
  endtask
  initial begin
    logic [54:0] wa, wb;
    int o0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
`ifndef RX_SYNC_EN
    repeat (100) drive_bit(1'b1);
    chk("stuck_busy", 64'(busy), 64'(0));
    chk("stuck_valid", 64'(rx_valid), 64'(0));
`endif
    repeat (3) drive_bit(1'b0);
    send_frame({3'b111, 52'd0});
    token_check("t1");
    ack_pulse();
    wa = {3'b010, 2'b01, 10'h3FF, {4{10'h1FF}}};
    send_frame(wa);
    repeat (LAT + 4) drive_bit(1'b0);
    chk("t2_held", 64'(rx_valid), 64'(1));
    chk("t2_data", 64'(RX_Data), 64'(wa));
    chk("t2_type", 64'(pkt_type), 64'(3'b010));
    ack_pulse();
    chk("t2_cleared", 64'(rx_valid), 64'(0));
    ack_rand = 1'b1;
    #1 o0 = ovr_cnt;
    wa = {3'b000, 52'({$urandom(), $urandom()})};
    wb = {3'b011, 52'({$urandom(), $urandom()})};
    send_frame(wa);
    send_frame(wb);
    repeat (LAT + 2) drive_bit(1'b0);
    #1;
    chk("t3_data", 64'(RX_Data), 64'(wb));
    chk("t3_no_ovr", 64'(ovr_cnt - o0), 64'(0));
    ack_rand = 1'b0;
    ack_pulse();
    o0 = ovr_cnt;
    wa = 55'({$urandom(), $urandom()});
    wb = 55'({$urandom(), $urandom()});
    send_frame(wa);
    send_frame(wb);
    repeat (LAT + 3) drive_bit(1'b0);
    #1;
    chk("t4_ovr_once", 64'(ovr_cnt - o0), 64'(1));
    chk("t4_data", 64'(RX_Data), 64'(wb));
    chk("t4_valid", 64'(rx_valid), 64'(1));
    ack_pulse();
    ack_rand = 1'b1;
    repeat (30) begin
      send_frame(55'({$urandom(), $urandom()}));
      repeat ($urandom_range(0, 4)) drive_bit(1'b1);
      repeat ($urandom_range(0, 4)) drive_bit(1'b0);
    end
    repeat (LAT + 3) drive_bit(1'b0);
    ack_rand = 1'b0;
    ack_pulse();
    start_frame(55'({$urandom(), $urandom()}));
    repeat (20) drive_bit(1'($urandom_range(0, 1)));
    chk("t5_midframe_busy", 64'(busy), 64'(1));
    do_reset();
    repeat (80) drive_bit(1'b0);
    chk("t5_no_abort_valid", 64'(rx_valid), 64'(0));
    send_frame({3'b111, 52'd0});
    token_check("t5");
    repeat (3) drive_bit(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
